coriolis_stream_ctrl: RTL and testbench
=======================================

CORIOLIS_STREAM_CTRL -- requirements
Module: coriolis_stream_ctrl

Interface
REQ-001 Parameter CNTW, default 16: width of the element counters and of n_elems.
REQ-002 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port start, input, 1: pulse that launches a job; sampled only in IDLE.
REQ-005 Port n_elems, input, CNTW: element count of the job; latched when start is accepted.
REQ-006 Port src_valid, input, 1: upstream u/v stream pair has data.
REQ-007 Port src_ready, output, 1: upstream u/v pair consumed this cycle when src_valid is also high.
REQ-008 Port k_ivalid, output, 1: drives both ivalid_u and ivalid_v of the kernel.
REQ-009 Port k_iready, input, 1: kernel iready.
REQ-010 Port k_ovalid, input, 1: kernel ovalid (un and vn both valid).
REQ-011 Port k_oready, output, 1: drives both oready_un and oready_vn of the kernel.
REQ-012 Port sink_valid, output, 1: un/vn pair offered downstream.
REQ-013 Port sink_ready, input, 1: downstream accepts the un/vn pair.
REQ-014 Port busy, output, 1: high in RUN and DRAIN.
REQ-015 Port done, output, 1: one-cycle completion pulse.
REQ-016 Port issued, output, CNTW: count of elements issued in the current job.
REQ-017 Port retired, output, CNTW: count of elements retired in the current job.
REQ-018 Port err, output, 1: sticky protocol-error flag.

Function
REQ-019 The FSM SHALL have four states: IDLE, RUN, DRAIN, FIN.
REQ-020 In IDLE, a start pulse SHALL latch n_elems, clear issued and retired, and go to RUN; if n_elems==0 it SHALL go directly to FIN.
REQ-021 A start pulse outside IDLE SHALL be ignored and SHALL NOT change latched n_elems or the counters.
REQ-022 Define can_issue = (state==RUN) & (issued < N).
REQ-023 k_ivalid SHALL equal src_valid & can_issue.
REQ-024 src_ready SHALL equal k_iready & can_issue.
REQ-025 Both outputs SHALL be combinational, so input-side latency is 0 cycles.
REQ-026 An issue SHALL occur on a cycle where src_valid, k_iready and can_issue are all high; issued SHALL increment by 1 on that cycle.
REQ-027 Define out_en = (state==RUN or state==DRAIN) & (retired < N).
REQ-028 sink_valid SHALL equal k_ovalid & out_en, and k_oready SHALL equal sink_ready & out_en (combinational).
REQ-029 A retire SHALL occur when k_ovalid, sink_ready and out_en are all high; retired SHALL increment by 1.
REQ-030 Issue and retire on the same cycle SHALL both be counted.
REQ-031 RUN SHALL go to DRAIN on the cycle issued reaches N (the transition is registered with the last issue).
REQ-032 If the last issue and the last retire coincide, RUN SHALL go directly to FIN.
REQ-033 DRAIN SHALL go to FIN on the cycle retired reaches N.
REQ-034 FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-035 busy SHALL be low in FIN.
REQ-036 issued and retired SHALL hold their final values in FIN and IDLE until the next accepted start.
REQ-037 Counters SHALL never exceed N; no wrap-around is possible, since N ≤ 2^CNTW−1.
REQ-038 err SHALL set when k_ovalid is high while out_en is low, in any state other than IDLE immediately after reset.
REQ-039 err SHALL also set if retired would exceed issued.
REQ-040 err SHALL clear only on rst.

Reset
REQ-041 rst SHALL force state to IDLE and clear issued, retired, latched N, done and err.
REQ-042 During rst, src_ready, k_ivalid, k_oready, sink_valid and busy SHALL be 0.
REQ-043 rst asserted mid-job SHALL abort the job without a done pulse; the first cycle after rst deasserts SHALL be in IDLE.

Verification
REQ-044 Scenario: n_elems=4, src_valid, k_iready and sink_ready held at 1, kernel latency 3 -> issued reaches 4 after 4 cycles, then DRAIN, retired reaches 4, one done pulse, busy low after FIN.
REQ-045 Scenario: n_elems=0 with a start pulse -> FIN on the next cycle, done pulses once, and k_ivalid, src_ready and busy never assert.
REQ-046 Scenario: n_elems=8 with random src_valid, k_iready and sink_ready (50%) -> exactly 8 issues and 8 retires, no transfer after count 8, err stays 0.
REQ-047 Scenario: start pulsed again while in RUN with n_elems=2 presented -> ignored; the original N=5 job completes with issued=5.
REQ-048 Scenario: rst asserted after 3 of 6 issues -> the next cycle is IDLE with counters 0, no done pulse, err=0.
REQ-049 Scenario: k_ovalid forced high in IDLE after a completed job -> err=1 and stays 1 until rst.

Source files
------------

// File: rtl/coriolis_stream_ctrl.sv
// Job-level flow controller around a Coriolis u/v -> un/vn streaming kernel.
// Counts issued and retired elements, gates both handshakes, and flags protocol errors.
module coriolis_stream_ctrl #(
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [CNTW-1:0] n_elems,
   input  logic            src_valid,
   output logic            src_ready,
   output logic            k_ivalid,
   input  logic            k_iready,
   input  logic            k_ovalid,
   output logic            k_oready,
   output logic            sink_valid,
   input  logic            sink_ready,
   output logic            busy,
   output logic            done,
   output logic [CNTW-1:0] issued,
   output logic [CNTW-1:0] retired,
   output logic            err
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [CNTW-1:0] r_n;
   logic [CNTW-1:0] r_issued;
   logic [CNTW-1:0] r_retired;
   logic [CNTW-1:0] w_issued_next;
   logic [CNTW-1:0] w_retired_next;
   logic            r_err;
   logic            r_seen;
   logic            w_active;
   logic            w_can_issue;
   logic            w_out_en;
   logic            w_issue;
   logic            w_retire;
   logic            w_ovalid_err;
   logic            w_order_err;

   // Gating with rst keeps every handshake quiet while the state register is being reset.
   assign w_active    = ~rst & ((r_state == S_RUN) | (r_state == S_DRAIN));
   assign w_can_issue = ~rst & (r_state == S_RUN) & (r_issued < r_n);
   assign w_out_en    = w_active & (r_retired < r_n);

   assign k_ivalid   = src_valid & w_can_issue;
   assign src_ready  = k_iready & w_can_issue;
   assign sink_valid = k_ovalid & w_out_en;
   assign k_oready   = sink_ready & w_out_en;
   assign busy       = w_active;
   assign done       = ~rst & (r_state == S_FIN);
   assign issued     = r_issued;
   assign retired    = r_retired;
   assign err        = r_err;

   assign w_issue        = src_valid & k_iready & w_can_issue;
   assign w_retire       = k_ovalid & sink_ready & w_out_en;
   assign w_issued_next  = r_issued + CNTW'(w_issue);
   assign w_retired_next = r_retired + CNTW'(w_retire);

   // A stray kernel output is tolerated only before the first job after reset.
   assign w_ovalid_err = k_ovalid & ~w_out_en & ~((r_state == S_IDLE) & ~r_seen);
   assign w_order_err  = w_retire &
                         ((CNTW+1)'(r_retired) >= ((CNTW+1)'(r_issued) + (CNTW+1)'(w_issue)));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = (n_elems == '0) ? S_FIN : S_RUN;
         end
         S_RUN: begin
            if (w_retired_next == r_n)     w_state_next = S_FIN;
            else if (w_issued_next == r_n) w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_retired_next == r_n) w_state_next = S_FIN;
         end
         S_FIN:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_n       <= '0;
         r_issued  <= '0;
         r_retired <= '0;
         r_err     <= 1'b0;
         r_seen    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == S_IDLE) && start) begin
            r_n       <= n_elems;
            r_issued  <= '0;
            r_retired <= '0;
            r_seen    <= 1'b1;
         end else begin
            r_issued  <= w_issued_next;
            r_retired <= w_retired_next;
         end
         if (w_ovalid_err | w_order_err) r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_coriolis_stream_ctrl.sv
// Randomized bench for coriolis_stream_ctrl: a job-level reference model plus a
// queue-based kernel model, compared against the DUT every cycle.
module tb_coriolis_stream_ctrl;
   localparam int CNTW = 16;

   logic            clk = 1'b0;
   logic            rst, start, src_valid, src_ready, k_ivalid, k_iready;
   logic            k_ovalid, k_oready, sink_valid, sink_ready, busy, done, err;
   logic [CNTW-1:0] n_elems, issued, retired;

   coriolis_stream_ctrl #(.CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .start(start), .n_elems(n_elems),
      .src_valid(src_valid), .src_ready(src_ready),
      .k_ivalid(k_ivalid), .k_iready(k_iready),
      .k_ovalid(k_ovalid), .k_oready(k_oready),
      .sink_valid(sink_valid), .sink_ready(sink_ready),
      .busy(busy), .done(done), .issued(issued), .retired(retired), .err(err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: job bookkeeping in plain integers.
   int m_n = 0, m_iss = 0, m_ret = 0;
   bit m_active = 0, m_fin = 0, m_seen = 0, m_err = 0;
   // Kernel model: per-element cycle at which its result becomes valid.
   int kq[$];
   int cyc = 0;
   int lat = 3;
   int p_src = 100, p_kir = 100, p_snk = 100;
   bit force_ov = 0;
   int done_seen = 0;

   task automatic drive_io();
      src_valid  = ($urandom_range(99) < p_src);
      k_iready   = ($urandom_range(99) < p_kir);
      sink_ready = ($urandom_range(99) < p_snk);
      k_ovalid   = force_ov || (kq.size() > 0 && kq[0] <= cyc);
   endtask

   task automatic cycle();
      bit can_iss, oen, iss, ret, idle_b;
      @(negedge clk);
      can_iss = !rst && m_active && (m_iss < m_n);
      oen     = !rst && m_active && (m_ret < m_n);
      idle_b  = !m_active && !m_fin;
      check("k_ivalid",   k_ivalid,   src_valid & can_iss);
      check("src_ready",  src_ready,  k_iready & can_iss);
      check("sink_valid", sink_valid, k_ovalid & oen);
      check("k_oready",   k_oready,   sink_ready & oen);
      check("busy",       busy,       !rst && m_active);
      check("done",       done,       !rst && m_fin);
      check("issued",     issued,     m_iss);
      check("retired",    retired,    m_ret);
      check("err",        err,        m_err);
      if (done === 1'b1) done_seen++;
      iss = src_valid & k_iready & can_iss;
      ret = k_ovalid & sink_ready & oen;
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_active = 0; m_fin = 0; m_seen = 0; m_err = 0;
         m_n = 0; m_iss = 0; m_ret = 0;
         kq.delete();
      end else begin
         if (k_ovalid && !oen && !(idle_b && !m_seen)) m_err = 1;
         if (ret && (m_ret + 1 > m_iss + int'(iss))) m_err = 1;
         if (iss) kq.push_back(cyc + lat);
         if (ret && kq.size() > 0) void'(kq.pop_front());
         if (m_fin) m_fin = 0;
         else if (idle_b) begin
            if (start) begin
               m_n = int'(n_elems); m_iss = 0; m_ret = 0; m_seen = 1;
               if (m_n == 0) m_fin = 1;
               else m_active = 1;
            end
         end else begin
            m_iss += int'(iss);
            m_ret += int'(ret);
            if (m_ret == m_n) begin
               m_active = 0;
               m_fin = 1;
            end
         end
      end
      #1;
      start = 1'b0;
      drive_io();
   endtask

   task automatic launch_job(input int n);
      n_elems = CNTW'(n);
      start = 1'b1;
      done_seen = 0;
      cycle();
   endtask

   task automatic finish_job(input int n, input string tag);
      for (int t = 0; t < 600 && (m_active || m_fin); t++) cycle();
      if (m_active || m_fin) check({tag, "_timeout"}, 1, 0);
      check({tag, "_issued"},  issued,    n);
      check({tag, "_retired"}, retired,   n);
      check({tag, "_dones"},   done_seen, 1);
      check({tag, "_busy"},    busy,      0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; n_elems = '0;
      src_valid = 1'b0; k_iready = 1'b0; k_ovalid = 1'b0; sink_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cycle();                       // reset-state outputs with rst held
      rst = 1'b0;

      // Stray ovalid straight after reset must not set err.
      force_ov = 1; drive_io();
      cycle(); cycle();
      check("post_rst_err", err, 0);
      force_ov = 0; drive_io();
      cycle();

      // Full-throughput job, kernel latency 3.
      lat = 3; p_src = 100; p_kir = 100; p_snk = 100; drive_io();
      launch_job(4);
      repeat (4) cycle();
      check("s1_issued4", issued, 4);
      check("s1_drain_busy", busy, 1);
      finish_job(4, "s1");
      cycle();

      // Empty job goes straight to FIN.
      launch_job(0);
      check("s2_fin_done", done, 1);
      check("s2_busy", busy, 0);
      finish_job(0, "s2");
      cycle();

      // Random handshakes, 50%.
      p_src = 50; p_kir = 50; p_snk = 50; lat = 2;
      launch_job(8);
      finish_job(8, "s3");
      repeat (5) cycle();
      check("s3_after_issued", issued, 8);
      check("s3_err", err, 0);

      // Second start during RUN is ignored.
      p_src = 100; p_kir = 100; p_snk = 100; lat = 3; drive_io();
      launch_job(5);
      repeat (2) cycle();
      n_elems = CNTW'(2); start = 1'b1;
      cycle();
      finish_job(5, "s4");
      cycle();

      // Reset mid-job after 3 issues.
      launch_job(6);
      for (int t = 0; t < 50 && m_iss < 3; t++) cycle();
      check("s5_reach3", issued, 3);
      rst = 1'b1;
      done_seen = 0;
      cycle();
      rst = 1'b0;
      cycle();
      check("s5_issued", issued, 0);
      check("s5_retired", retired, 0);
      check("s5_busy", busy, 0);
      check("s5_err", err, 0);
      check("s5_dones", done_seen, 0);
      repeat (3) cycle();

      // Assorted random jobs.
      for (int j = 0; j < 6; j++) begin
         int n;
         n = $urandom_range(1, 20);
         lat = $urandom_range(1, 4);
         p_src = $urandom_range(30, 100);
         p_kir = $urandom_range(30, 100);
         p_snk = $urandom_range(30, 100);
         launch_job(n);
         finish_job(n, "rnd");
         repeat ($urandom_range(0, 3)) cycle();
      end
      check("rnd_err", err, 0);

      // Stray ovalid in IDLE after a completed job sets sticky err.
      force_ov = 1; drive_io();
      cycle(); cycle();
      check("s6_err_set", err, 1);
      force_ov = 0; drive_io();
      repeat (4) cycle();
      check("s6_err_sticky", err, 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      check("s6_err_cleared", err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
